// File: rtl/router_pkg.sv
// Shared types and defaults for the multi-channel router control FSM.
package router_pkg;

    // Default configuration of the router.
    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_WAIT_TO = 64;

    // Controller states, 4-bit encoding with DECODE at zero so reset lands there.
    typedef enum logic [3:0] {
        ST_DECODE     = 4'd0,
        ST_LFD        = 4'd1,
        ST_LOAD       = 4'd2,
        ST_FULL       = 4'd3,
        ST_LAF        = 4'd4,
        ST_LOAD_PAR   = 4'd5,
        ST_CHK_PAR    = 4'd6,
        ST_WAIT_EMPTY = 4'd7,
        ST_DROP       = 4'd8
    } state_t;

    // Address field width for a given channel count; never narrower than one bit.
    function automatic int addr_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// Bundle between the packet source / register block / FIFOs and the router FSM.
interface router_fsm_nch_if
    import router_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = addr_width(NUM_CH)
);
    // Source and register-block side
    logic              pkt_valid;
    logic              low_pkt_valid;
    logic              parity_done;
    logic [ADDR_W-1:0] data_in;
    // FIFO side
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    // State decodes and status
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              write_enb_reg;
    logic              busy;
    logic              drop_state;
    logic [ADDR_W-1:0] addr_q;
    logic              timeout_err;

    // Surrounding logic: drives the FSM inputs, observes its decodes.
    modport master (
        output pkt_valid, low_pkt_valid, parity_done, data_in,
               fifo_full, fifo_empty, soft_reset,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, drop_state, addr_q, timeout_err
    );

    // The router FSM itself.
    modport slave (
        input  pkt_valid, low_pkt_valid, parity_done, data_in,
               fifo_full, fifo_empty, soft_reset,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, drop_state, addr_q, timeout_err
    );

endinterface

// File: rtl/router_wait_timer.sv
// Cycle counter bounding how long the router waits for a busy destination FIFO.
// Only instantiated when ROUTER_FSM_TIMEOUT_EN is defined.
module router_wait_timer #(
    parameter int WAIT_TO = 64
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int                CNT_W = (WAIT_TO > 1) ? $clog2(WAIT_TO) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WAIT_TO - 1);

    logic [CNT_W-1:0] count;

    // Count waiting cycles, saturating at the last one until cleared.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/router_fsm_nch.sv
// Control FSM of an N-channel packet router: decodes the header address,
// steers writes into the selected FIFO, handles full/parity phases, and
// drops packets addressed to channels that do not exist.
// Optional build macro ROUTER_FSM_TIMEOUT_EN bounds the WAIT_EMPTY phase.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int ADDR_W  = addr_width(NUM_CH),
    parameter int WAIT_TO = DEF_WAIT_TO
) (
    input  logic             clock,
    input  logic             resetn,
    router_fsm_nch_if.slave  bus
);
    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic              in_range;     // data_in names an existing channel
    logic              empty_in;     // fifo_empty of the channel on data_in
    logic              empty_q;      // fifo_empty of the latched channel
    logic              sreset_q;     // soft_reset of the latched channel
    logic              expired;
    logic              timeout_hit;

    // Select per-channel flags without ever indexing past the last channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        in_range = 1'b0;
        empty_in = 1'b0;
        empty_q  = 1'b0;
        sreset_q = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.data_in) == i) begin
                in_range = 1'b1;
                empty_in = bus.fifo_empty[i];
            end
            if (int'(addr_q) == i) begin
                empty_q  = bus.fifo_empty[i];
                sreset_q = bus.soft_reset[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_DECODE;
        else         state <= next_state;
    end

    // Destination latch, loaded whenever a header is seen in DECODE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
        end else if ((state == ST_DECODE) && bus.pkt_valid) begin
            addr_q <= bus.data_in;
        end
    end

    // Next-state logic; a soft reset of the active channel overrides everything.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        unique case (state)
            ST_DECODE: begin
                if (bus.pkt_valid) begin
                    if (!in_range)     next_state = ST_DROP;
                    else if (empty_in) next_state = ST_LFD;
                    else               next_state = ST_WAIT_EMPTY;
                end
            end
            ST_LFD:  next_state = ST_LOAD;
            ST_LOAD: begin
                if (bus.fifo_full)       next_state = ST_FULL;
                else if (!bus.pkt_valid) next_state = ST_LOAD_PAR;
            end
            ST_FULL: begin
                if (!bus.fifo_full) next_state = ST_LAF;
            end
            ST_LAF: begin
                if (bus.parity_done)        next_state = ST_DECODE;
                else if (bus.low_pkt_valid) next_state = ST_LOAD_PAR;
                else                        next_state = ST_LOAD;
            end
            ST_LOAD_PAR: next_state = ST_CHK_PAR;
            ST_CHK_PAR:  next_state = bus.fifo_full ? ST_FULL : ST_DECODE;
            ST_WAIT_EMPTY: begin
                if (empty_q) begin
                    next_state = ST_LFD;
                end else if (expired) begin
                    next_state  = ST_DROP;
                    timeout_hit = 1'b1;
                end
            end
            ST_DROP: begin
                if (!bus.pkt_valid) next_state = ST_DECODE;
            end
            default: next_state = ST_DECODE;
        endcase
        if ((state != ST_DECODE) && sreset_q) begin
            next_state  = ST_DECODE;
            timeout_hit = 1'b0;
        end
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    logic timeout_q;

    router_wait_timer #(.WAIT_TO(WAIT_TO)) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (state != ST_WAIT_EMPTY),
        .enable  (state == ST_WAIT_EMPTY),
        .expired (expired)
    );

    // One-cycle error pulse coinciding with the forced move into DROP.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) timeout_q <= 1'b0;
        else         timeout_q <= timeout_hit;
    end

    assign bus.timeout_err = timeout_q;
`else
    // Without the timeout WAIT_EMPTY waits forever; WAIT_TO has no effect.
    logic unused_cfg;
    assign expired         = 1'b0;
    assign unused_cfg      = timeout_hit ^ (WAIT_TO != 0);
    assign bus.timeout_err = 1'b0;
`endif

    // Moore decodes of the state register.
    assign bus.detect_add    = (state == ST_DECODE);
    assign bus.lfd_state     = (state == ST_LFD);
    assign bus.ld_state      = (state == ST_LOAD);
    assign bus.full_state    = (state == ST_FULL);
    assign bus.laf_state     = (state == ST_LAF);
    assign bus.rst_int_reg   = (state == ST_CHK_PAR);
    assign bus.drop_state    = (state == ST_DROP);
    assign bus.write_enb_reg = (state inside {ST_LOAD, ST_LOAD_PAR, ST_LAF});
    assign bus.busy          = (state inside {ST_LFD, ST_FULL, ST_LAF,
                                              ST_LOAD_PAR, ST_CHK_PAR, ST_WAIT_EMPTY});
    assign bus.addr_q        = addr_q;

endmodule
